adc_result_capture: RTL and testbench
=====================================

Name: adc_result_capture

Overview:
- Downstream of the ADC conversion controller.
- Captures the ADC's 8-bit parallel result during the controller's one-cycle output-enable pulse (g_d), tagged with the channel code on addr.
- Block-averages 2^AVG_LOG2 samples per channel and publishes one averaged register per channel, with update pulses and health flags for display/logic stages.

Parameters:
- DW, 8, ADC data width.
- AVG_LOG2, 2, log2 of samples averaged per channel (N = 4).
- TIMEOUT, 1023, clocks without an accepted sample before stale asserts.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- g_d  in  1  ADC output-enable pulse from controller; adc_data valid while high.
- addr  in  2  channel code during g_d: 2'b00 = ch0, 2'b01 = ch1 (y), 2'b10 = ch2 (x), 2'b11 = illegal.
- adc_data  in  DW  ADC result bus.
- clr_err  in  1  synchronous clear of err_addr and overrun.
- avg_ch0  out  DW  latest average, channel 00.
- avg_ch1  out  DW  latest average, channel 01.
- avg_ch2  out  DW  latest average, channel 10.
- upd  out  3  one-cycle pulse; bit k set when avg_chk is refreshed.
- err_addr  out  1  sticky; a g_d was seen with addr = 2'b11.
- overrun  out  1  sticky; a g_d arrived while the FSM was busy.
- stale  out  1  no sample accepted for TIMEOUT clocks.

Behaviour:
- Reset (async, any state): FSM to IDLE. All outputs, sums, counts, data_r, ch_r and the timeout counter clear to 0. Partial accumulations are discarded.
- FSM states: IDLE, ACC, PUB.
  - IDLE, g_d = 1, addr != 11: data_r <= adc_data, ch_r <= addr, timeout counter <= 0, stale <= 0, go to ACC.
  - IDLE, g_d = 1, addr = 11: err_addr <= 1, sample dropped, stay IDLE. The timeout counter is not reset.
  - ACC: sum[ch_r] <= sum[ch_r] + data_r; cnt[ch_r] <= cnt[ch_r] + 1. If the old cnt[ch_r] = N-1, go to PUB, else go to IDLE.
  - PUB: avg_ch[ch_r] <= sum[ch_r] >> AVG_LOG2 (truncating); sum[ch_r] <= 0; cnt[ch_r] <= 0; upd[ch_r] <= 1 for exactly one cycle; go to IDLE.
- Arithmetic:
  - sum per channel is DW+AVG_LOG2 bits and cannot overflow.
  - cnt per channel is AVG_LOG2 bits.
  - The three channels accumulate independently; interleaved channels are legal.
- Latency (g_d sampled high at edge E0):
  - ACC occupies E0..E1; sum updated at E1.
  - On the Nth sample, PUB occupies E1..E2; avg and upd update at E2; upd clears at E3.
- Busy: g_d = 1 while in ACC or PUB sets overrun and drops the sample (sum, cnt and data_r unchanged). The controller's ≥7-clock cycle never causes this in normal operation.
- clr_err: clears err_addr and overrun at the next edge. If a new error event occurs in the same cycle, the set wins.
- Timeout counter:
  - Increments every clock in which no sample is accepted, and saturates at TIMEOUT.
  - stale is registered high on the edge where the counter reaches TIMEOUT.
  - stale stays high until the next accepted sample.
- upd bits are mutually exclusive. avg_chk holds its value between updates.

Test Plan:
- Reset mid-ACC: after 3 ch1 samples, pulse reset. Then apply 4 samples 8,8,8,8 -> avg_ch1 = 8; no stale data contributes.
- Channel averaging: ch1 (addr 01) samples 10, 20, 30, 41 at 8-clock spacing.
  - upd = 3'b010 for exactly one cycle, 2 edges after the 4th capture edge.
  - avg_ch1 = 25.
  - avg_ch0 and avg_ch2 remain 0.
- Interleave and full scale: alternate addr 00 (0xFF ×4) and addr 10 (0x01, 0x02, 0x03, 0x04) -> avg_ch0 = 0xFF, avg_ch2 = 2; upd pulses at 3'b001 and 3'b100, never overlapping.
- Illegal address: g_d with addr = 11, data 0x55 -> err_addr = 1, no sum change. Then clr_err -> err_addr = 0. Then clr_err asserted in the same cycle as another addr = 11 event -> err_addr stays 1.
- Overrun: g_d in IDLE, then g_d again on the following cycle (FSM in ACC) -> overrun = 1; only the first sample counted (cnt = 1).
- Timeout (bench TIMEOUT = 20): no g_d for 20 clocks -> stale = 1 at the 20th edge. The next legal g_d clears stale at its capture edge.

Source files
------------

// File: rtl/adc_result_capture.sv
// adc_result_capture: captures ADC results on the controller's g_d pulse,
// block-averages 2^AVG_LOG2 samples per channel and publishes one averaged
// register per channel, with one-cycle update pulses and health flags.
module adc_result_capture #(
    parameter int unsigned DW       = 8,
    parameter int unsigned AVG_LOG2 = 2,
    parameter int unsigned TIMEOUT  = 1023
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          g_d,
    input  logic [1:0]    addr,
    input  logic [DW-1:0] adc_data,
    input  logic          clr_err,
    output logic [DW-1:0] avg_ch0,
    output logic [DW-1:0] avg_ch1,
    output logic [DW-1:0] avg_ch2,
    output logic [2:0]    upd,
    output logic          err_addr,
    output logic          overrun,
    output logic          stale
);

    localparam int unsigned NCH = 3;
    localparam int unsigned SW  = DW + AVG_LOG2;       // sum of N samples never overflows
    localparam int unsigned CW  = AVG_LOG2;
    localparam int unsigned TW  = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] CNT_LAST = '1;            // N-1
    localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_PUB  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   data_q,  data_d;
    logic [1:0]      ch_q,    ch_d;
    logic [SW-1:0]   sum_q [NCH];
    logic [SW-1:0]   sum_d [NCH];
    logic [CW-1:0]   cnt_q [NCH];
    logic [CW-1:0]   cnt_d [NCH];
    logic [DW-1:0]   avg_q [NCH];
    logic [DW-1:0]   avg_d [NCH];
    logic [2:0]      upd_q,   upd_d;
    logic            err_q,   err_d;
    logic            ovr_q,   ovr_d;
    logic [TW-1:0]   tcnt_q,  tcnt_d;
    logic            stale_q, stale_d;
    logic            accept;

    // Next-state logic: FSM, per-channel accumulation, flags and timeout counter.
    always_comb begin
        // NOTE: every target gets a default first, so no path can infer a latch.
        state_d = state_q;
        data_d  = data_q;
        ch_d    = ch_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        avg_d   = avg_q;
        upd_d   = '0;
        err_d   = err_q & ~clr_err;
        ovr_d   = ovr_q & ~clr_err;
        tcnt_d  = tcnt_q;
        stale_d = stale_q;
        accept  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (g_d) begin
                    if (addr == 2'b11) begin
                        err_d = 1'b1;
                    end else begin
                        data_d  = adc_data;
                        ch_d    = addr;
                        accept  = 1'b1;
                        state_d = S_ACC;
                    end
                end
            end
            S_ACC: begin
                if (g_d) ovr_d = 1'b1;
                state_d = S_IDLE;
                for (int k = 0; k < NCH; k++) begin
                    if (ch_q == 2'(k)) begin
                        sum_d[k] = sum_q[k] + SW'(data_q);
                        cnt_d[k] = cnt_q[k] + CW'(1);
                        if (cnt_q[k] == CNT_LAST) state_d = S_PUB;
                    end
                end
            end
            S_PUB: begin
                if (g_d) ovr_d = 1'b1;
                state_d = S_IDLE;
                for (int k = 0; k < NCH; k++) begin
                    if (ch_q == 2'(k)) begin
                        avg_d[k] = DW'(sum_q[k] >> AVG_LOG2);
                        sum_d[k] = '0;
                        cnt_d[k] = '0;
                        upd_d[k] = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            tcnt_d  = '0;
            stale_d = 1'b0;
        end else begin
            if (tcnt_q != TMAX) tcnt_d = tcnt_q + TW'(1);
            stale_d = stale_q | (tcnt_d == TMAX);
        end
    end

    // State register with asynchronous reset of every register, sums and counts included.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            ch_q    <= '0;
            // NOTE: the per-channel arrays are small register files that must
            // clear on reset so a partial block never leaks into a later average.
            for (int k = 0; k < NCH; k++) begin
                sum_q[k] <= '0;
                cnt_q[k] <= '0;
                avg_q[k] <= '0;
            end
            upd_q   <= '0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
            tcnt_q  <= '0;
            stale_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q <= state_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            avg_q   <= avg_d;
            upd_q   <= upd_d;
            err_q   <= err_d;
            ovr_q   <= ovr_d;
            tcnt_q  <= tcnt_d;
            stale_q <= stale_d;
        end
    end

    assign avg_ch0  = avg_q[0];
    assign avg_ch1  = avg_q[1];
    assign avg_ch2  = avg_q[2];
    assign upd      = upd_q;
    assign err_addr = err_q;
    assign overrun  = ovr_q;
    assign stale    = stale_q;

endmodule

// File: tb/tb_adc_result_capture.sv
// Scoreboard bench for adc_result_capture: stimulus feeds a per-channel
// block-average model that queues expected publications; a monitor pops
// them whenever upd pulses and checks channel, timing and all averages.
module tb_adc_result_capture;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       g_d = 1'b0;
    logic [1:0] addr = 2'b00;
    logic [7:0] adc_data = 8'h00;
    logic       clr_err = 1'b0;
    logic [7:0] avg_ch0, avg_ch1, avg_ch2;
    logic [2:0] upd;
    logic       err_addr, overrun, stale;

    adc_result_capture #(.DW(8), .AVG_LOG2(2), .TIMEOUT(20)) dut (
        .clk      (clk),
        .reset    (reset),
        .g_d      (g_d),
        .addr     (addr),
        .adc_data (adc_data),
        .clr_err  (clr_err),
        .avg_ch0  (avg_ch0),
        .avg_ch1  (avg_ch1),
        .avg_ch2  (avg_ch2),
        .upd      (upd),
        .err_addr (err_addr),
        .overrun  (overrun),
        .stale    (stale)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: running block sum and sample count per channel.
    typedef struct {
        int ch;
        int avg;
        int due;
    } exp_t;

    exp_t exp_q[$];
    int   acc_sum [3];
    int   acc_n   [3];
    int   shadow  [3];

    task automatic model_flush();
        exp_q.delete();
        for (int k = 0; k < 3; k++) begin
            acc_sum[k] = 0;
            acc_n[k]   = 0;
            shadow[k]  = 0;
        end
    endtask

    task automatic model_accept(input int ch, input int d, input int cap);
        acc_sum[ch] += d;
        acc_n[ch]++;
        if (acc_n[ch] == 4) begin
            exp_q.push_back('{ch: ch, avg: acc_sum[ch] / 4, due: cap + 2});
            acc_sum[ch] = 0;
            acc_n[ch]   = 0;
        end
    endtask

    // One g_d pulse; returns the index of the capture edge.
    task automatic send(input logic [1:0] a, input logic [7:0] d, output int cap);
        @(negedge clk);
        g_d = 1'b1; addr = a; adc_data = d;
        cap = cyc + 1;
        if (a != 2'b11) model_accept(int'(a), int'(d), cap);
        @(negedge clk);
        g_d = 1'b0; addr = 2'($urandom_range(3)); adc_data = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        model_flush();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: every upd pulse must match the oldest queued publication.
    exp_t e;
    always @(negedge clk) begin
        if (!reset) begin
            if (upd != 3'b000) begin
                if (exp_q.size() == 0) begin
                    check("upd_unexpected", int'(upd), 0);
                end else begin
                    e = exp_q.pop_front();
                    shadow[e.ch] = e.avg;
                    check("upd_onehot", int'(upd), 1 << e.ch);
                    check("upd_cycle", cyc, e.due);
                    check("avg_ch0", int'(avg_ch0), shadow[0]);
                    check("avg_ch1", int'(avg_ch1), shadow[1]);
                    check("avg_ch2", int'(avg_ch2), shadow[2]);
                end
            end else if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
                check("upd_missing", int'(upd), 1 << exp_q[0].ch);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cap;
        model_flush();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_avg_ch0", int'(avg_ch0), 0);
        check("rst_avg_ch1", int'(avg_ch1), 0);
        check("rst_avg_ch2", int'(avg_ch2), 0);
        check("rst_upd", int'(upd), 0);
        check("rst_err_addr", int'(err_addr), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_stale", int'(stale), 0);

        // Reset mid-accumulation discards the partial block
        send(2'b01, 8'd100, cap); idle(3);
        send(2'b01, 8'd200, cap); idle(3);
        send(2'b01, 8'd50, cap);
        pulse_reset();
        check("midacc_avg_ch1", int'(avg_ch1), 0);
        check("midacc_upd", int'(upd), 0);
        for (int i = 0; i < 4; i++) begin
            send(2'b01, 8'd8, cap); idle(3);
        end
        idle(2);
        check("after_reset_avg_ch1", int'(avg_ch1), 8);

        // Channel averaging at 8-clock spacing: (10+20+30+41)/4 = 25
        send(2'b01, 8'd10, cap); idle(6);
        send(2'b01, 8'd20, cap); idle(6);
        send(2'b01, 8'd30, cap); idle(6);
        send(2'b01, 8'd41, cap); idle(6);
        check("avg_ch1_25", int'(avg_ch1), 25);
        check("avg_ch0_zero", int'(avg_ch0), 0);
        check("avg_ch2_zero", int'(avg_ch2), 0);

        // Interleaved full scale on ch0 and small values on ch2
        for (int i = 0; i < 4; i++) begin
            send(2'b00, 8'hFF, cap); idle(2);
            send(2'b10, 8'(i + 1), cap); idle(2);
        end
        idle(4);
        check("interleave_avg_ch0", int'(avg_ch0), 255);
        check("interleave_avg_ch2", int'(avg_ch2), 2);

        // Illegal address: flag set, sample dropped
        send(2'b11, 8'h55, cap);
        check("illegal_err_set", int'(err_addr), 1);
        idle(2);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("illegal_err_cleared", int'(err_addr), 0);
        g_d = 1'b1; addr = 2'b11; adc_data = 8'h55; clr_err = 1'b1;
        @(negedge clk);
        g_d = 1'b0; clr_err = 1'b0;
        check("illegal_set_wins", int'(err_addr), 1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("illegal_err_cleared2", int'(err_addr), 0);
        // the dropped 0x55 samples must not reach the ch2 block
        for (int i = 0; i < 4; i++) begin
            send(2'b10, 8'd4, cap); idle(2);
        end
        idle(3);
        check("illegal_no_sum_ch2", int'(avg_ch2), 4);

        // Overrun: second pulse lands while the FSM is in ACC
        check("pre_overrun", int'(overrun), 0);
        @(negedge clk);
        g_d = 1'b1; addr = 2'b00; adc_data = 8'd40;
        model_accept(0, 40, cyc + 1);
        @(negedge clk);
        adc_data = 8'd200;
        @(negedge clk);
        g_d = 1'b0;
        check("overrun_set", int'(overrun), 1);
        idle(2);
        for (int i = 0; i < 3; i++) begin
            send(2'b00, 8'd20, cap); idle(2);
        end
        idle(3);
        check("overrun_single_count", int'(avg_ch0), 25);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("overrun_cleared", int'(overrun), 0);

        // Timeout: stale rises on the 20th idle edge, clears on next capture
        send(2'b01, 8'd77, cap);
        while (cyc < cap + 19) @(negedge clk);
        check("stale_before", int'(stale), 0);
        @(negedge clk);
        check("stale_at_timeout", int'(stale), 1);
        idle(5);
        check("stale_held", int'(stale), 1);
        send(2'b01, 8'd77, cap);
        check("stale_cleared", int'(stale), 0);
        idle(3);

        // Randomized traffic across the three channels
        for (int i = 0; i < 80; i++) begin
            send(2'($urandom_range(2)), 8'($urandom_range(255)), cap);
            idle(int'($urandom_range(6, 2)));
        end
        idle(10);
        check("pending_expect", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
